// File: rtl/mmio_bridge_pkg.sv
// Shared decode constants and read-source encoding for the MMIO bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mmio_bridge_pkg;

  // Upper address bits that steer an access to the I/O block instead of RAM
  localparam logic [1:0]  IO_SEL  = 2'b11;
  // UART data port: write pushes TX, read pops RX
  localparam logic [17:0] IO_UART = 18'h30000;
  // Cycle-counter window base (four little-endian bytes); write here halts
  localparam logic [17:0] IO_CLK  = 18'h30004;

  // Where the byte returned on cpu_din in the cycle after a read comes from
  typedef enum logic [2:0] {
    SRC_RAM,
    SRC_RX,
    SRC_CNT0,
    SRC_CNT1,
    SRC_CNT2,
    SRC_CNT3,
    SRC_ZERO
  } rd_src_e;

  // Map a byte offset inside the counter window to its read source
  function automatic rd_src_e cnt_src(input logic [1:0] idx);
    case (idx)
      2'd0:    return SRC_CNT0;
      2'd1:    return SRC_CNT1;
      2'd2:    return SRC_CNT2;
      default: return SRC_CNT3;
    endcase
  endfunction

endpackage

// File: rtl/mmio_bridge_sync_fifo.sv
// Generic single-clock FIFO with registered occupancy count.
// Latency: push visible at head one cycle later; head_dat is a combinational read.
// Backpressure: push ignored when full, pop ignored when empty; flags are registered.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage; pointers wrap naturally at DEPTH
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous clear
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty flag masks stale entries
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_bridge.sv
// CPU-to-RAM/UART/cycle-counter memory-mapped bridge with halt flag.
// Latency: read data on cpu_din one cycle after acceptance; RAM write same cycle.
// Backpressure: cpu_rdy drops on RX-empty read, TX-full push, reset or halt.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_halt
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  // Decode
  logic [17:0] io_addr;
  logic        io_sel, is_uart, is_clk, is_clk0;
  logic [1:0]  clk_byte;

  // Access control
  logic       tx_need, rx_need, stall, accept;
  logic [7:0] tx_push_dat;
  logic       tx_push, tx_pop, rx_push, rx_pop;

  // FIFO status
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]       tx_head, rx_head;
  logic [TX_CW-1:0] tx_count;
  logic [RX_CW-1:0] rx_count;

  // Registered state
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] latch_q, latch_d;
  logic        halt_q, halt_d;
  rd_src_e     src_q, src_d;
  logic [7:0]  rx_byte_q, rx_byte_d;

  // Upper CPU address bits and FIFO counts are intentionally not consumed
  logic unused_sig;
  assign unused_sig = ^{cpu_a[31:18], tx_count, rx_count};

  assign io_addr  = cpu_a[17:0];
  assign io_sel   = (cpu_a[17:16] == IO_SEL);
  assign is_uart  = io_sel && (io_addr == IO_UART);
  assign is_clk   = io_sel && (io_addr[17:2] == IO_CLK[17:2]);
  assign clk_byte = io_addr[1:0];
  assign is_clk0  = is_clk && (clk_byte == 2'd0);

  assign ram_a     = cpu_a[16:0];
  assign ram_din   = cpu_dout;
  assign prog_halt = halt_q;

  // Stall/accept decision from the live request and registered FIFO flags
  always_comb begin
    tx_need     = 1'b0;
    tx_push_dat = cpu_dout;
    if (cpu_wr && is_uart && (cpu_dout != 8'h00)) begin
      tx_need = 1'b1;
    end
    if (cpu_wr && is_clk0) begin
      tx_need     = 1'b1;
      tx_push_dat = 8'h00;
    end
    rx_need = !cpu_wr && is_uart;
    stall   = (tx_need && tx_full) || (rx_need && rx_empty);
    cpu_rdy = !rst_in && !halt_q && !stall;
    accept  = cpu_rdy;
    tx_push = accept && tx_need;
    rx_pop  = accept && rx_need;
    ram_we  = accept && cpu_wr && !io_sel;
  end

  // UART stream handshakes; both directions are held off during reset
  always_comb begin
    tx_valid = !rst_in && !tx_empty;
    tx_data  = tx_head;
    tx_pop   = tx_valid && tx_ready;
    rx_ready = !rst_in && !rx_full;
    rx_push  = rx_valid && rx_ready;
  end

  // Next values for counter, snapshot latch, halt flag and read source
  always_comb begin
    cnt_d     = cnt_q + 32'd1;
    latch_d   = latch_q;
    halt_d    = halt_q;
    src_d     = SRC_ZERO;
    rx_byte_d = rx_byte_q;
    if (accept && cpu_wr && is_clk0) begin
      halt_d = 1'b1;
    end
    if (accept && !cpu_wr) begin
      if (!io_sel) begin
        src_d = SRC_RAM;
      end else if (is_uart) begin
        src_d     = SRC_RX;
        rx_byte_d = rx_head;
      end else if (is_clk) begin
        src_d = cnt_src(clk_byte);
        if (is_clk0) begin
          latch_d = cnt_q;
        end
      end
    end
  end

  // Bridge state register with synchronous clear
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      latch_q   <= '0;
      halt_q    <= 1'b0;
      src_q     <= SRC_ZERO;
      rx_byte_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      latch_q   <= latch_d;
      halt_q    <= halt_d;
      src_q     <= src_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  // Return the byte selected at acceptance; forced to zero while in reset
  always_comb begin
    cpu_din = 8'h00;
    if (!rst_in) begin
      case (src_q)
        SRC_RAM:  cpu_din = ram_dout;
        SRC_RX:   cpu_din = rx_byte_q;
        SRC_CNT0: cpu_din = latch_q[7:0];
        SRC_CNT1: cpu_din = latch_q[15:8];
        SRC_CNT2: cpu_din = latch_q[23:16];
        SRC_CNT3: cpu_din = latch_q[31:24];
        default:  cpu_din = 8'h00;
      endcase
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (tx_push),
    .push_dat (tx_push_dat),
    .pop      (tx_pop),
    .head_dat (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (rx_push),
    .push_dat (rx_data),
    .pop      (rx_pop),
    .head_dat (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge.
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns later.
// Backpressure: the bench plays CPU, RAM and both UART stream ends.
module tb_mmio_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [16:0] ram_a;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_halt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  mmio_bridge dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .cpu_a     (cpu_a),
    .cpu_dout  (cpu_dout),
    .cpu_wr    (cpu_wr),
    .cpu_din   (cpu_din),
    .cpu_rdy   (cpu_rdy),
    .ram_a     (ram_a),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .prog_halt (prog_halt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a    = a;
    cpu_wr   = wr;
    cpu_dout = d;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 8'h00);
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in   = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    ram_dout = 8'h00;
    // RAM write presented during reset must not strobe
    drive(32'h0000_0010, 1'b1, 8'hC3);
    tick();
    tick();
    settle();
    check("rst_cpu_din",   cpu_din,   0);
    check("rst_tx_valid",  tx_valid,  0);
    check("rst_rx_ready",  rx_ready,  0);
    check("rst_ram_we",    ram_we,    0);
    check("rst_cpu_rdy",   cpu_rdy,   0);
    check("rst_prog_halt", prog_halt, 0);
    idle();
    rst_in = 1'b0;
    settle();
    check("post_rst_rdy", cpu_rdy, 1);

    // RAM read: data one cycle after acceptance
    drive(32'h0000_0010, 1'b0, 8'h00);
    settle();
    check("ram_rd_addr", ram_a, 17'h00010);
    check("ram_rd_rdy",  cpu_rdy, 1);
    tick();
    ram_dout = 8'hA5;
    idle();
    settle();
    check("ram_rd_data", cpu_din, 8'hA5);
    check("ram_rd_rdy2", cpu_rdy, 1);

    // RAM write at the top of RAM space (bits 17:16 = 10)
    drive(32'h0002_0033, 1'b1, 8'h5A);
    settle();
    check("ram_wr_we",   ram_we,  1);
    check("ram_wr_data", ram_din, 8'h5A);
    check("ram_wr_addr", ram_a,   17'h00033);
    tick();

    // Unmapped I/O write ignored, unmapped I/O read returns zero
    drive(32'h0003_0008, 1'b1, 8'h77);
    settle();
    check("io_wr_no_we",  ram_we,  0);
    check("io_wr_rdy",    cpu_rdy, 1);
    tick();
    settle();
    check("io_wr_no_tx",  tx_valid, 0);
    drive(32'h0003_0008, 1'b0, 8'h00);
    ram_dout = 8'hEE;
    tick();
    idle();
    settle();
    check("io_rd_zero", cpu_din, 8'h00);

    // TX: 0x41, 0x00 (dropped), 0x42
    drive(32'h0003_0000, 1'b1, 8'h41);
    tick();
    drive(32'h0003_0000, 1'b1, 8'h00);
    settle();
    check("tx_zero_rdy", cpu_rdy, 1);
    tick();
    drive(32'h0003_0000, 1'b1, 8'h42);
    tick();
    idle();
    settle();
    check("tx_first_vld", tx_valid, 1);
    check("tx_first_dat", tx_data,  8'h41);
    tx_ready = 1'b1;
    tick();
    settle();
    check("tx_second_vld", tx_valid, 1);
    check("tx_second_dat", tx_data,  8'h42);
    tick();
    settle();
    check("tx_drained", tx_valid, 0);
    tx_ready = 1'b0;

    // RX read on empty FIFO stalls until a byte arrives
    drive(32'h0003_0000, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      settle();
      check("rx_empty_stall", cpu_rdy, 0);
      if (i == 4) begin
        rx_data  = 8'h37;
        rx_valid = 1'b1;
        settle();
        check("rx_ready_open", rx_ready, 1);
      end
      tick();
    end
    rx_valid = 1'b0;
    settle();
    check("rx_release", cpu_rdy, 1);
    tick();
    settle();
    check("rx_data_37", cpu_din, 8'h37);
    check("rx_empty_again", cpu_rdy, 0);
    idle();

    // RX ordering with a simultaneous push and pop
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    tick();
    rx_data = 8'h22;
    tick();
    rx_data = 8'h33;
    drive(32'h0003_0000, 1'b0, 8'h00);
    tick();
    rx_valid = 1'b0;
    settle();
    check("rx_ord_0", cpu_din, 8'h11);
    tick();
    settle();
    check("rx_ord_1", cpu_din, 8'h22);
    tick();
    settle();
    check("rx_ord_2", cpu_din, 8'h33);
    check("rx_ord_empty", cpu_rdy, 0);
    idle();
    tick();

    // TX full: eight writes fill, ninth stalls through the pop cycle
    for (int i = 1; i <= 8; i++) begin
      drive(32'h0003_0000, 1'b1, 8'(i));
      settle();
      check("tx_fill_rdy", cpu_rdy, 1);
      tick();
    end
    drive(32'h0003_0000, 1'b1, 8'h09);
    settle();
    check("tx_full_stall", cpu_rdy, 0);
    tick();
    settle();
    check("tx_full_hold", cpu_rdy, 0);
    tx_ready = 1'b1;
    settle();
    check("tx_pop_head", tx_data, 8'h01);
    check("tx_pop_cycle_stall", cpu_rdy, 0);
    tick();
    tx_ready = 1'b0;
    settle();
    check("tx_after_pop_rdy", cpu_rdy, 1);
    tick();
    idle();
    tx_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      settle();
      check("tx_drain_vld", tx_valid, 1);
      check("tx_drain_dat", tx_data,  32'(i));
      tick();
    end
    settle();
    check("tx_drain_done", tx_valid, 0);
    tx_ready = 1'b0;

    // Counter snapshot: 0x1FF edges after reset, then read the four bytes
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    repeat (511) tick();
    drive(32'h0003_0004, 1'b0, 8'h00);
    tick();
    drive(32'h0003_0005, 1'b0, 8'h00);
    settle();
    check("cnt_byte0", cpu_din, 8'hFF);
    tick();
    drive(32'h0003_0006, 1'b0, 8'h00);
    settle();
    check("cnt_byte1", cpu_din, 8'h01);
    tick();
    drive(32'h0003_0007, 1'b0, 8'h00);
    settle();
    check("cnt_byte2", cpu_din, 8'h00);
    tick();
    idle();
    settle();
    check("cnt_byte3", cpu_din, 8'h00);

    // Halt: write 0x30004 pushes 0x00 and stops the CPU
    drive(32'h0003_0004, 1'b1, 8'h99);
    settle();
    check("halt_wr_rdy", cpu_rdy, 1);
    tick();
    drive(32'h0000_0010, 1'b1, 8'h55);
    settle();
    check("halt_set",      prog_halt, 1);
    check("halt_tx_vld",   tx_valid,  1);
    check("halt_tx_dat",   tx_data,   8'h00);
    check("halt_rdy_low",  cpu_rdy,   0);
    check("halt_no_we",    ram_we,    0);
    tick();
    settle();
    check("halt_sticky", prog_halt, 1);
    idle();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    settle();
    check("halt_cleared",   prog_halt, 0);
    check("halt_tx_flush",  tx_valid,  0);
    check("halt_rdy_back",  cpu_rdy,   1);
    repeat (3) tick();
    drive(32'h0003_0004, 1'b0, 8'h00);
    tick();
    idle();
    settle();
    check("cnt_restart", cpu_din, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameter TX_DEPTH, default 8, UART transmit FIFO depth in bytes (power of two, >=2).
REQ-002 Parameter RX_DEPTH, default 8, UART receive FIFO depth in bytes (power of two, >=2).
REQ-003 clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 cpu_a  input  32  CPU byte address; only bits 17:0 are decoded.
REQ-006 cpu_dout  input  8  write data from the CPU.
REQ-007 cpu_wr  input  1  1 = write, 0 = read.
REQ-008 cpu_din  output  8  read data to the CPU, valid the cycle after the accepted read.
REQ-009 cpu_rdy  output  1  0 = CPU paused; the CPU holds cpu_a, cpu_wr and cpu_dout while low.
REQ-010 ram_a  output  17  RAM address, equal to cpu_a[16:0].
REQ-011 ram_din  output  8  RAM write data, equal to cpu_dout.
REQ-012 ram_we  output  1  RAM write strobe.
REQ-013 ram_dout  input  8  RAM read data, one-cycle synchronous read.
REQ-014 tx_data  output  8 / tx_valid  output  1 / tx_ready  input  1  UART TX valid/ready stream.
REQ-015 rx_data  input  8 / rx_valid  input  1 / rx_ready  output  1  UART RX valid/ready stream.
REQ-016 prog_halt  output  1  sticky program-stop flag.

Function
REQ-017 Address decode: cpu_a[17:16]==2'b11 selects I/O; any other value selects RAM.
REQ-018 An access is accepted in a cycle when cpu_rdy=1.
REQ-019 RAM write: ram_we = accepted & cpu_wr & RAM-selected & ~prog_halt.
REQ-020 Read data timing: the read source is registered at acceptance, and cpu_din is muxed from that register in the following cycle.
REQ-021 Read data sources: RAM returns ram_dout; 0x30000 returns the popped RX byte; 0x30004-0x30007 return counter bytes; any other I/O address returns 0x00.
REQ-022 Cycle counter: 32-bit, cleared by reset, +1 every cycle, wraps 0xFFFFFFFF->0.
REQ-023 Read 0x30004: snapshots the counter into a 32-bit latch and returns latch[7:0].
REQ-024 Reads of 0x30005/6/7 return latch bytes 1/2/3 (little-endian) without re-snapshot.
REQ-025 Read 0x30000 with RX FIFO non-empty: pops one byte and returns it next cycle.
REQ-026 Read 0x30000 with RX FIFO empty: cpu_rdy=0 until the FIFO is non-empty; no pop occurs.
REQ-027 Write 0x30000, non-zero data: push cpu_dout to TX FIFO; data 0x00 is ignored (no push, no stall).
REQ-028 Write 0x30004: push 0x00 to TX FIFO and set prog_halt=1 in the following cycle.
REQ-029 Write to any other I/O address is ignored.
REQ-030 TX full stall: a write that requires a push while the TX FIFO is full gives cpu_rdy=0.
REQ-031 TX full vs. pop: fullness is evaluated from registered state, so a same-cycle TX pop does not release the stall until the next cycle.
REQ-032 cpu_rdy is combinational from the current request and registered FIFO flags; it also goes 0 permanently once prog_halt=1.
REQ-033 TX stream: tx_valid = TX non-empty, tx_data = head byte, pop on tx_valid&tx_ready; bytes leave in FIFO order.
REQ-034 RX stream: rx_ready = RX not full, push on rx_valid&rx_ready.
REQ-035 RX simultaneous push and pop when non-empty and not full: count unchanged, order preserved.
REQ-036 FIFO pointers wrap modulo depth; full and empty are distinguished by an occupancy count.

Reset
REQ-037 On rst_in=1 at a clock edge: FIFOs emptied, counter=0, latch=0, prog_halt=0, read-source register cleared.
REQ-038 While rst_in=1: cpu_din=0x00, tx_valid=0, rx_ready=0, ram_we=0, cpu_rdy=0.
REQ-039 Reset mid-stall or mid-transfer: the pending access is discarded and no push or pop completes.

Structure
REQ-040 Shared package holds the I/O constants IO_SEL (2'b11), IO_UART (18'h30000) and IO_CLK (18'h30004), plus the read-source enum (RAM, RX, CNT0-3, ZERO).
REQ-041 One sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count), instantiated for TX and for RX.

Verification
REQ-042 Read RAM 0x00010 (ram_dout=0xA5) -> cpu_din=0xA5 one cycle after acceptance, cpu_rdy stays 1.
REQ-043 Writes 0x41, 0x00, 0x42 to 0x30000, tx_ready=1 -> tx stream carries exactly 0x41 then 0x42.
REQ-044 Counter at 0x000001FF, reads 0x30004..0x30007 over four consecutive cycles -> 0xFF, 0x01, 0x00, 0x00.
REQ-045 Read 0x30000 with RX empty, rx_data=0x37 valid 5 cycles later -> cpu_rdy low for 5 cycles, then cpu_din=0x37.
REQ-046 tx_ready=0, 9 non-zero writes with TX_DEPTH=8 -> 9th write stalls (cpu_rdy=0) until one pop, and the pop cycle itself still stalls.
REQ-047 Write 0x30004 then rst_in pulse -> tx_data=0x00 pushed and prog_halt=1; after reset prog_halt=0 and counter=0.
